// File: rtl/nes_joypad_pkg.sv
// Shared constants and types for the NES-style joypad register port.
package nes_joypad_pkg;

  typedef logic [7:0] buttons_t;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam logic [15:0] ADDR_P1_DEFAULT  = 16'h4016;
  localparam logic [15:0] ADDR_P2_DEFAULT  = 16'h4017;
  localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'h40;

endpackage

// File: rtl/joypad_shifter.sv
// One controller port: latest-sample snapshot plus the serial shift register read by the CPU.
module joypad_shifter
  import nes_joypad_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     strobe,
  input  logic     strobe_fall,
  input  logic     rd,
  input  buttons_t sample,
  input  logic     sample_valid,
  output logic     d0
);

  buttons_t snap_q, snap_d;
  buttons_t shift_q, shift_d;

  always_comb begin
    snap_d  = sample_valid ? sample : snap_q;
    shift_d = shift_q;
    // A sample arriving on a load cycle wins over the stored snapshot.
    if (strobe || strobe_fall) begin
      shift_d = sample_valid ? sample : snap_q;
    end else if (rd) begin
      shift_d = {1'b1, shift_q[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q  <= '0;
      shift_q <= '1;
    end else begin
      snap_q  <= snap_d;
      shift_q <= shift_d;
    end
  end

  assign d0 = shift_q[0];

endmodule

// File: rtl/joypad_port.sv
// CPU-facing joypad strobe/data registers; port 2 is built only when JOYPAD_PORT2_EN is defined.
module joypad_port
  import nes_joypad_pkg::*;
#(
  parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEFAULT,
  parameter logic [15:0] ADDR_P1  = ADDR_P1_DEFAULT,
  parameter logic [15:0] ADDR_P2  = ADDR_P2_DEFAULT
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [7:0]  buttons1,
  input  logic        buttons1_valid,
  input  logic [7:0]  buttons2,
  input  logic        buttons2_valid,
  input  logic        cpu_en,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid
);

  logic       strobe_q, strobe_d;
  logic       wr_p1, strobe_fall;
  logic       rd_p1, rd_p2;
  logic       p1_d0, p2_d0;
  logic [7:0] rdata_q, rdata_d;
  logic       rvalid_q, rvalid_d;
  logic       unused_wdata;

  assign wr_p1       = cpu_en && !cpu_rw && (cpu_addr == ADDR_P1);
  assign rd_p1       = cpu_en &&  cpu_rw && (cpu_addr == ADDR_P1);
  assign rd_p2       = cpu_en &&  cpu_rw && (cpu_addr == ADDR_P2);
  assign strobe_d    = wr_p1 ? cpu_wdata[0] : strobe_q;
  assign strobe_fall = wr_p1 && strobe_q && !cpu_wdata[0];
  assign unused_wdata = ^cpu_wdata[7:1];

  joypad_shifter u_p1 (
    .clk          (clk),
    .rst_n        (Reset),
    .strobe       (strobe_q),
    .strobe_fall  (strobe_fall),
    .rd           (rd_p1),
    .sample       (buttons1),
    .sample_valid (buttons1_valid),
    .d0           (p1_d0)
  );

`ifdef JOYPAD_PORT2_EN
  joypad_shifter u_p2 (
    .clk          (clk),
    .rst_n        (Reset),
    .strobe       (strobe_q),
    .strobe_fall  (strobe_fall),
    .rd           (rd_p2),
    .sample       (buttons2),
    .sample_valid (buttons2_valid),
    .d0           (p2_d0)
  );
`else
  logic unused_p2;
  assign unused_p2 = ^{buttons2, buttons2_valid};
  assign p2_d0     = 1'b0;
`endif

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (rd_p1) begin
      rdata_d  = {OPEN_BUS[7:1], p1_d0};
      rvalid_d = 1'b1;
    end else if (rd_p2) begin
      rdata_d  = {OPEN_BUS[7:1], p2_d0};
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      strobe_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;

endmodule

// File: tb/tb_joypad_port.sv
// Directed bench for joypad_port with a per-cycle reference model of the serial pad protocol.
module tb_joypad_port;

`ifdef JOYPAD_PORT2_EN
  localparam logic P2EN = 1'b1;
`else
  localparam logic P2EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  buttons1 = '0;
  logic        buttons1_valid = 1'b0;
  logic [7:0]  buttons2 = '0;
  logic        buttons2_valid = 1'b0;
  logic        cpu_en = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  joypad_port #(
    .OPEN_BUS (8'h40),
    .ADDR_P1  (16'h4016),
    .ADDR_P2  (16'h4017)
  ) dut (
    .clk            (clk),
    .Reset          (Reset),
    .buttons1       (buttons1),
    .buttons1_valid (buttons1_valid),
    .buttons2       (buttons2),
    .buttons2_valid (buttons2_valid),
    .cpu_en         (cpu_en),
    .cpu_rw         (cpu_rw),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_rvalid     (cpu_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each port is "the byte latched at the last load" plus
  // how many bits the CPU has consumed since; past 8 bits the line reads 1.
  logic [7:0]  m_snap1, m_snap2, m_lat1, m_lat2;
  int unsigned m_n1, m_n2;
  logic        m_strobe;
  logic [7:0]  exp_rdata = '0;
  logic        exp_rvalid = 1'b0;

  function automatic logic port_bit(input logic [7:0] lat, input int unsigned n);
    if (n < 8) return lat[n[2:0]];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge Reset) begin
    logic rd1, rd2, wr1, fall;
    if (!Reset) begin
      m_strobe = 1'b0;
      m_snap1 = 8'h00; m_snap2 = 8'h00;
      m_lat1 = 8'hFF;  m_lat2 = 8'hFF;
      m_n1 = 0;        m_n2 = 0;
      exp_rdata = 8'h00;
      exp_rvalid = 1'b0;
    end else begin
      rd1 = cpu_en && cpu_rw && cpu_addr == 16'h4016;
      rd2 = cpu_en && cpu_rw && cpu_addr == 16'h4017;
      wr1 = cpu_en && !cpu_rw && cpu_addr == 16'h4016;
      if (rd1) begin
        exp_rdata = {7'h20, port_bit(m_lat1, m_n1)};
        exp_rvalid = 1'b1;
      end else if (rd2) begin
        exp_rdata = {7'h20, P2EN ? port_bit(m_lat2, m_n2) : 1'b0};
        exp_rvalid = 1'b1;
      end else begin
        exp_rvalid = 1'b0;
      end
      fall = wr1 && m_strobe && !cpu_wdata[0];
      if (m_strobe || fall) begin
        m_lat1 = buttons1_valid ? buttons1 : m_snap1;
        m_lat2 = buttons2_valid ? buttons2 : m_snap2;
        m_n1 = 0;
        m_n2 = 0;
      end else begin
        if (rd1 && m_n1 < 8) m_n1++;
        if (rd2 && m_n2 < 8) m_n2++;
      end
      if (buttons1_valid) m_snap1 = buttons1;
      if (buttons2_valid) m_snap2 = buttons2;
      if (wr1) m_strobe = cpu_wdata[0];
    end
  end

  always @(negedge clk) begin
    check("model_rvalid", {7'b0, cpu_rvalid}, {7'b0, exp_rvalid});
    check("model_rdata", cpu_rdata, exp_rdata);
  end

  task automatic cpu_read(input logic [15:0] a, input string name,
                          input logic [7:0] exp, input logic expv);
    @(negedge clk);
    cpu_en = 1'b1; cpu_rw = 1'b1; cpu_addr = a;
    @(negedge clk);
    cpu_en = 1'b0;
    check(name, cpu_rdata, exp);
    check({name, "_valid"}, {7'b0, cpu_rvalid}, {7'b0, expv});
  endtask

  task automatic rdp1(input string name, input logic b);
    cpu_read(16'h4016, name, {7'h20, b}, 1'b1);
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d,
                           input logic v1, input logic [7:0] b1);
    @(negedge clk);
    cpu_en = 1'b1; cpu_rw = 1'b0; cpu_addr = a; cpu_wdata = d;
    if (v1) begin
      buttons1 = b1;
      buttons1_valid = 1'b1;
    end
    @(negedge clk);
    cpu_en = 1'b0; cpu_rw = 1'b1; buttons1_valid = 1'b0;
  endtask

  task automatic pulse1(input logic [7:0] b);
    @(negedge clk);
    buttons1 = b; buttons1_valid = 1'b1;
    @(negedge clk);
    buttons1_valid = 1'b0;
  endtask

  task automatic pulse2(input logic [7:0] b);
    @(negedge clk);
    buttons2 = b; buttons2_valid = 1'b1;
    @(negedge clk);
    buttons2_valid = 1'b0;
  endtask

  initial begin
    int s89[10]  = '{1, 0, 0, 1, 0, 0, 0, 1, 1, 1};
    int s89b[7]  = '{1, 0, 0, 0, 1, 1, 1};
    int s02[9]   = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    logic [7:0] p2v;

    #1 Reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rdata", cpu_rdata, 8'h00);
    check("reset_rvalid", {7'b0, cpu_rvalid}, 8'h00);
    Reset = 1'b1;

    rdp1("first_read", 1'b1);

    pulse1(8'b1000_1001);
    cpu_write(16'h4016, 8'h01, 1'b0, 8'h00);
    cpu_write(16'h4016, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) rdp1("seq89", s89[i][0]);

    cpu_write(16'h4016, 8'h01, 1'b0, 8'h00);
    pulse1(8'h01);
    rdp1("strobe_live_1", 1'b1);
    pulse1(8'h00);
    rdp1("strobe_live_0", 1'b0);
    rdp1("strobe_noshift", 1'b0);

    pulse1(8'b1000_1001);
    cpu_write(16'h4016, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) rdp1("seq_pre_pulse", s89[i][0]);
    pulse1(8'hFF);
    for (int i = 0; i < 7; i++) rdp1("seq_post_pulse", s89b[i][0]);

    cpu_write(16'h4016, 8'h01, 1'b0, 8'h00);
    cpu_write(16'h4016, 8'h00, 1'b1, 8'h02);
    for (int i = 0; i < 9; i++) rdp1("same_cycle_latch", s02[i][0]);

    pulse2(8'h01);
    cpu_write(16'h4016, 8'h01, 1'b0, 8'h00);
    cpu_write(16'h4016, 8'h00, 1'b0, 8'h00);
    p2v = {7'h20, P2EN};
    cpu_read(16'h4017, "p2_read", p2v, 1'b1);
    cpu_read(16'h4018, "bad_addr_hold", p2v, 1'b0);
    cpu_write(16'h4017, 8'h01, 1'b0, 8'h00);
    cpu_write(16'h4018, 8'h01, 1'b0, 8'h00);
    rdp1("after_ignored_wr0", 1'b0);
    rdp1("after_ignored_wr1", 1'b1);

    pulse1(8'h00);
    cpu_write(16'h4016, 8'h01, 1'b0, 8'h00);
    cpu_write(16'h4016, 8'h00, 1'b0, 8'h00);
    rdp1("pre_reset_0", 1'b0);
    rdp1("pre_reset_1", 1'b0);
    @(negedge clk);
    #2 Reset = 1'b0;
    @(negedge clk);
    check("midreset_rdata", cpu_rdata, 8'h00);
    check("midreset_rvalid", {7'b0, cpu_rvalid}, 8'h00);
    #2 Reset = 1'b1;
    rdp1("post_reset_0", 1'b1);
    rdp1("post_reset_1", 1'b1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
